// File: rtl/audio_reader_pkg.sv
// Shared types and constants for the flash-backed audio sample reader.
// Song bounds are flash word addresses; each word carries two 16-bit samples.
package audio_reader_pkg;

   localparam int FLASH_ADDR_W = 23;
   localparam logic [FLASH_ADDR_W-1:0] SONG_START = 23'h000000;
   localparam logic [FLASH_ADDR_W-1:0] SONG_END   = 23'h07FFFF;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ       = 2'd1,
      WAIT_VALID = 2'd2,
      EMIT       = 2'd3
   } reader_state_t;

   function automatic logic [15:0] pick_half(input logic [31:0] word, input logic high);
      pick_half = high ? word[31:16] : word[15:0];
   endfunction

endpackage

// File: rtl/audio_sample_reader_if.sv
// Avalon-MM pipelined read bus between the sample reader and flash.
// The reader owns the master side; the flash controller owns the slave side.
interface audio_sample_reader_if #(
   parameter int ADDR_W = 23
);
   logic              flash_read;
   logic [ADDR_W-1:0] flash_address;
   logic              flash_waitrequest;
   logic [31:0]       flash_readdata;
   logic              flash_readdatavalid;

   modport master (
      output flash_read,
      output flash_address,
      input  flash_waitrequest,
      input  flash_readdata,
      input  flash_readdatavalid
   );

   modport slave (
      input  flash_read,
      input  flash_address,
      output flash_waitrequest,
      output flash_readdata,
      output flash_readdatavalid
   );
endinterface

// File: rtl/sample_addr_counter.sv
// Flash word-address counter for the current song position.
// Steps up or down by one word and wraps between the song bounds.
module sample_addr_counter #(
   parameter int                ADDR_W     = 23,
   parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
   parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              step,
   input  logic              dir,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_value,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_next_s;

   // Next position: load wins over step; stepping past either bound wraps.
   always_comb begin
      addr_next_s = addr_r;
      if (load) begin
         addr_next_s = load_value;
      end else if (step) begin
         if (!dir) begin
            addr_next_s = (addr_r == END_ADDR) ? START_ADDR : addr_r + ONE;
         end else begin
            addr_next_s = (addr_r == START_ADDR) ? END_ADDR : addr_r - ONE;
         end
      end else begin
         addr_next_s = addr_r;
      end
   end

   // Address register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         addr_r <= START_ADDR;
      end else begin
         addr_r <= addr_next_s;
      end
   end

   assign addr = addr_r;

endmodule

// File: rtl/audio_sample_reader.sv
// Supplies one 16-bit sample per sample_tick, fetching 32-bit flash words
// over Avalon-MM and unpacking two samples per word in either play direction.
module audio_sample_reader
   import audio_reader_pkg::*;
#(
   parameter int                ADDR_W     = FLASH_ADDR_W,
   parameter logic [ADDR_W-1:0] START_ADDR = SONG_START,
   parameter logic [ADDR_W-1:0] END_ADDR   = SONG_END
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         sample_tick,
   input  logic                         play,
   input  logic                         dir,
   input  logic                         restart,
   audio_sample_reader_if.master        flash,
   output logic [15:0]                  sample_out,
   output logic                         sample_valid,
   output logic                         missed_tick
);

   reader_state_t     state_r, state_next_s;
   logic              flash_read_r, flash_read_s;
   logic [15:0]       sample_out_r, sample_out_s;
   logic              sample_valid_r, sample_valid_s;
   logic              missed_r, missed_s;
   logic              need_fetch_r, need_fetch_s;
   logic              order_r, order_s;
   logic [31:0]       word_r, word_s;
   logic              pend_r, pend_s;
   logic              step_s;
   logic              apply_restart_s;
   logic [ADDR_W-1:0] load_value_s;
   logic [ADDR_W-1:0] addr_s;

   assign load_value_s = dir ? END_ADDR : START_ADDR;

   sample_addr_counter #(
      .ADDR_W     (ADDR_W),
      .START_ADDR (START_ADDR),
      .END_ADDR   (END_ADDR)
   ) u_addr (
      .clk        (clk),
      .clr        (clr),
      .step       (step_s),
      .dir        (dir),
      .load       (apply_restart_s),
      .load_value (load_value_s),
      .addr       (addr_s)
   );

   // Sequencing and next values for every datapath register.
   always_comb begin
      state_next_s    = state_r;
      flash_read_s    = 1'b0;
      sample_out_s    = sample_out_r;
      sample_valid_s  = 1'b0;
      missed_s        = missed_r;
      need_fetch_s    = need_fetch_r;
      order_s         = order_r;
      word_s          = word_r;
      pend_s          = pend_r;
      step_s          = 1'b0;
      apply_restart_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (restart) begin
               apply_restart_s = 1'b1;
            end else if (sample_tick && play) begin
               if (need_fetch_r) begin
                  state_next_s = READ;
                  flash_read_s = 1'b1;
               end else begin
                  state_next_s   = EMIT;
                  sample_valid_s = 1'b1;
                  sample_out_s   = pick_half(word_r, !order_r);
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         READ: begin
            missed_s = missed_r | sample_tick;
            pend_s   = pend_r | restart;
            if (flash.flash_waitrequest) begin
               flash_read_s = 1'b1;
            end else begin
               state_next_s = WAIT_VALID;
            end
         end
         WAIT_VALID: begin
            missed_s = missed_r | sample_tick;
            pend_s   = pend_r | restart;
            if (flash.flash_readdatavalid) begin
               // A restart requested while the read was in flight drops this word.
               if (pend_r || restart) begin
                  apply_restart_s = 1'b1;
               end else begin
                  state_next_s   = EMIT;
                  word_s         = flash.flash_readdata;
                  order_s        = dir;
                  sample_out_s   = pick_half(flash.flash_readdata, dir);
                  sample_valid_s = 1'b1;
               end
            end else begin
               state_next_s = WAIT_VALID;
            end
         end
         EMIT: begin
            state_next_s = IDLE;
            missed_s     = missed_r | sample_tick;
            if (restart) begin
               apply_restart_s = 1'b1;
            end else if (need_fetch_r) begin
               need_fetch_s = 1'b0;
            end else begin
               need_fetch_s = 1'b1;
               step_s       = 1'b1;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      state_next_s = apply_restart_s ? IDLE : state_next_s;
      need_fetch_s = apply_restart_s ? 1'b1 : need_fetch_s;
      missed_s     = apply_restart_s ? 1'b0 : missed_s;
      pend_s       = apply_restart_s ? 1'b0 : pend_s;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         flash_read_r   <= 1'b0;
         sample_out_r   <= 16'h0000;
         sample_valid_r <= 1'b0;
         missed_r       <= 1'b0;
         need_fetch_r   <= 1'b1;
         order_r        <= 1'b0;
         word_r         <= 32'h0000_0000;
         pend_r         <= 1'b0;
      end else begin
         flash_read_r   <= flash_read_s;
         sample_out_r   <= sample_out_s;
         sample_valid_r <= sample_valid_s;
         missed_r       <= missed_s;
         need_fetch_r   <= need_fetch_s;
         order_r        <= order_s;
         word_r         <= word_s;
         pend_r         <= pend_s;
      end
   end

   assign flash.flash_read    = flash_read_r;
   assign flash.flash_address = addr_s;
   assign sample_out          = sample_out_r;
   assign sample_valid        = sample_valid_r;
   assign missed_tick         = missed_r;

endmodule

// File: tb/tb_audio_sample_reader.sv
// Scoreboard bench for audio_sample_reader: a flash slave model with adjustable
// waitrequest and latency, expected read addresses and samples queued per tick.
module tb_audio_sample_reader;
   import audio_reader_pkg::*;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        sample_tick = 1'b0;
   logic        play = 1'b1;
   logic        dir = 1'b0;
   logic        restart = 1'b0;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        missed_tick;

   audio_sample_reader_if #(.ADDR_W(FLASH_ADDR_W)) bus();

   audio_sample_reader #(
      .ADDR_W     (FLASH_ADDR_W),
      .START_ADDR (SONG_START),
      .END_ADDR   (SONG_END)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .sample_tick  (sample_tick),
      .play         (play),
      .dir          (dir),
      .restart      (restart),
      .flash        (bus),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .missed_tick  (missed_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int sv_count = 0;
   int reads_seen = 0;
   int wait_cycles = 0;
   int latency = 3;
   int wcnt = 0;
   int rcnt = 0;
   int sv_before;
   int rd_before;
   logic [FLASH_ADDR_W-1:0] raddr = '0;
   logic [31:0] mem [int];
   logic [FLASH_ADDR_W-1:0] exp_addr [$];
   logic [15:0] exp_samp [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Flash slave: waitrequest for wait_cycles, data latency cycles after acceptance.
   initial begin
      bus.flash_waitrequest   = 1'b0;
      bus.flash_readdatavalid = 1'b0;
      bus.flash_readdata      = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.flash_readdatavalid = 1'b0;
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               bus.flash_readdatavalid = 1'b1;
               bus.flash_readdata = mem.exists(int'(raddr)) ? mem[int'(raddr)] : 32'hDEAD_BEEF;
            end
         end
         if (bus.flash_read) begin
            reads_seen++;
            if (wcnt < wait_cycles) begin
               bus.flash_waitrequest = 1'b1;
               wcnt++;
            end else begin
               bus.flash_waitrequest = 1'b0;
               wcnt  = 0;
               raddr = bus.flash_address;
               rcnt  = latency;
               if (exp_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL read_addr: unexpected read at %0h", bus.flash_address);
               end else begin
                  chk("read_addr", 32'(bus.flash_address), 32'(exp_addr.pop_front()));
               end
            end
         end else begin
            bus.flash_waitrequest = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Sample monitor: every sample_valid pulse must match the head of the queue.
   always @(negedge clk) begin
      if (sample_valid) begin
         sv_count++;
         if (exp_samp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sample: unexpected sample_valid with %0h", sample_out);
         end else begin
            chk("sample", 32'(sample_out), 32'(exp_samp.pop_front()));
         end
      end
   end

   task automatic wait_valid(input int exp_lat, input string name);
      int n = 1;
      while (!sample_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!sample_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: no sample_valid within %0d cycles", name, n);
      end else if (exp_lat > 0) begin
         chk({name, "_latency"}, 32'(n), 32'(exp_lat));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic raise_tick();
      @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
   endtask

   task automatic do_tick(input int exp_lat, input string name);
      raise_tick();
      wait_valid(exp_lat, name);
   endtask

   task automatic pulse_restart();
      @(posedge clk);
      #1 restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      mem[32'h00000] = 32'hBBBB_AAAA;
      mem[32'h00001] = 32'hDDDD_CCCC;
      mem[32'h00002] = 32'h6666_5555;
      mem[32'h7FFFF] = 32'h2222_1111;
      idle_cycles(3);
      clr = 1'b0;
      chk("rst_read", 32'(bus.flash_read), 32'h0);
      chk("rst_addr", 32'(bus.flash_address), 32'h0);
      chk("rst_sample", 32'(sample_out), 32'h0);
      chk("rst_valid", 32'(sample_valid), 32'h0);
      chk("rst_missed", 32'(missed_tick), 32'h0);

      // Forward playback through two words.
      exp_addr.push_back(23'h0); exp_samp.push_back(16'hAAAA); do_tick(5, "fwd_fetch0");
      exp_samp.push_back(16'hBBBB); do_tick(1, "fwd_second0");
      exp_addr.push_back(23'h1); exp_samp.push_back(16'hCCCC); do_tick(5, "fwd_fetch1");
      exp_samp.push_back(16'hDDDD); do_tick(1, "fwd_second1");

      // Three waitrequest cycles: request held stable for four cycles.
      wait_cycles = 3;
      exp_addr.push_back(23'h2); exp_samp.push_back(16'h5555);
      raise_tick();
      for (int c = 1; c <= 4; c++) begin
         chk("stall_read", 32'(bus.flash_read), 32'h1);
         chk("stall_addr", 32'(bus.flash_address), 32'h2);
         @(posedge clk);
         #1;
      end
      chk("stall_drop", 32'(bus.flash_read), 32'h0);
      wait_valid(-1, "stall");
      wait_cycles = 0;
      exp_samp.push_back(16'h6666); do_tick(1, "stall_second");

      // Paused ticks do nothing.
      play = 1'b0;
      sv_before = sv_count;
      rd_before = reads_seen;
      repeat (5) raise_tick();
      idle_cycles(4);
      chk("pause_valid", 32'(sv_count), 32'(sv_before));
      chk("pause_reads", 32'(reads_seen), 32'(rd_before));
      chk("pause_sample", 32'(sample_out), 32'h6666);
      play = 1'b1;

      // Backward from the song end.
      dir = 1'b1;
      pulse_restart();
      chk("bwd_restart_addr", 32'(bus.flash_address), 32'h7FFFF);
      exp_addr.push_back(23'h7FFFF); exp_samp.push_back(16'h2222); do_tick(5, "bwd_fetch");
      exp_samp.push_back(16'h1111); do_tick(1, "bwd_second");
      chk("bwd_next_addr", 32'(bus.flash_address), 32'h7FFFE);

      // Backward wrap at address 0, then forward wrap at the end.
      dir = 1'b0;
      pulse_restart();
      dir = 1'b1;
      exp_addr.push_back(23'h0); exp_samp.push_back(16'hBBBB); do_tick(5, "bwrap_fetch");
      exp_samp.push_back(16'hAAAA); do_tick(1, "bwrap_second");
      chk("bwd_wrap_addr", 32'(bus.flash_address), 32'h7FFFF);
      dir = 1'b0;
      exp_addr.push_back(23'h7FFFF); exp_samp.push_back(16'h1111); do_tick(5, "fwrap_fetch");
      exp_samp.push_back(16'h2222); do_tick(1, "fwrap_second");
      chk("fwd_wrap_addr", 32'(bus.flash_address), 32'h0);
      exp_addr.push_back(23'h0); exp_samp.push_back(16'hAAAA); do_tick(5, "fwrap_next");
      exp_samp.push_back(16'hBBBB); do_tick(1, "fwrap_next2");

      // Tick during WAIT_VALID sets the sticky flag until restart.
      exp_addr.push_back(23'h1); exp_samp.push_back(16'hCCCC);
      raise_tick();
      @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
      chk("missed_set", 32'(missed_tick), 32'h1);
      wait_valid(-1, "missed_fetch");
      exp_samp.push_back(16'hDDDD); do_tick(1, "missed_second");
      chk("missed_sticky", 32'(missed_tick), 32'h1);
      pulse_restart();
      chk("missed_cleared", 32'(missed_tick), 32'h0);
      chk("restart_addr", 32'(bus.flash_address), 32'h0);

      // Restart during WAIT_VALID discards the in-flight word.
      exp_addr.push_back(23'h0); exp_samp.push_back(16'hAAAA); do_tick(5, "pre_fetch");
      exp_samp.push_back(16'hBBBB); do_tick(1, "pre_second");
      exp_addr.push_back(23'h1);
      sv_before = sv_count;
      raise_tick();
      @(posedge clk);
      #1 restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
      idle_cycles(6);
      chk("discard_valid", 32'(sv_count), 32'(sv_before));
      chk("discard_addr", 32'(bus.flash_address), 32'h0);
      exp_addr.push_back(23'h0); exp_samp.push_back(16'hAAAA); do_tick(5, "after_restart");
      exp_samp.push_back(16'hBBBB); do_tick(1, "after_restart2");

      // clr while the request is stalled in READ.
      wait_cycles = 10;
      raise_tick();
      @(posedge clk);
      #1;
      chk("clr_pre_read", 32'(bus.flash_read), 32'h1);
      #2 clr = 1'b1;
      #1;
      chk("clr_read", 32'(bus.flash_read), 32'h0);
      chk("clr_addr", 32'(bus.flash_address), 32'h0);
      chk("clr_sample", 32'(sample_out), 32'h0);
      chk("clr_valid", 32'(sample_valid), 32'h0);
      chk("clr_missed", 32'(missed_tick), 32'h0);
      @(posedge clk);
      #1 clr = 1'b0;
      wait_cycles = 0;

      // clr in WAIT_VALID: the late data arrives in IDLE and is ignored.
      exp_addr.push_back(23'h0);
      sv_before = sv_count;
      raise_tick();
      @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      idle_cycles(6);
      chk("late_valid", 32'(sv_count), 32'(sv_before));
      chk("late_sample", 32'(sample_out), 32'h0);
      chk("late_read", 32'(bus.flash_read), 32'h0);
      exp_addr.push_back(23'h0); exp_samp.push_back(16'hAAAA); do_tick(5, "post_clr");

      idle_cycles(4);
      chk("samples_left", 32'(exp_samp.size()), 32'h0);
      chk("reads_left", 32'(exp_addr.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
